// File: rtl/stack_bank.sv
// Bank of STACKS independent LIFO stacks with peek/push/pop/replace, flush,
// occupancy status and one-cycle overflow/underflow/dout_valid pulses.
module stack_bank #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 16,
   parameter int STACKS = 4,
   localparam int SEL_W = (STACKS > 1) ? $clog2(STACKS) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req,
   input  logic [1:0]       op,
   input  logic [SEL_W-1:0] sel,
   input  logic [WIDTH-1:0] din,
   input  logic             flush,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             overflow,
   output logic             underflow,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] OP_PEEK    = 2'b00;
   localparam logic [1:0] OP_PUSH    = 2'b01;
   localparam logic [1:0] OP_POP     = 2'b10;
   localparam logic [1:0] OP_REPLACE = 2'b11;

   logic [CNT_W-1:0]  sp  [STACKS];
   logic [WIDTH-1:0]  mem [STACKS][DEPTH];

   logic              sel_ok;
   logic [CNT_W-1:0]  cur_sp;
   logic              cur_full, cur_empty;
   logic [ADDR_W-1:0] top_idx, wr_idx, wr_addr;
   logic              do_op, is_push;
   logic              push_ok, push_rej, rd_ok, rd_rej, pop_ok, wr_en;

   // req is sampled on every edge with no backpressure; dout_valid, overflow
   // and underflow report the outcome of the op sampled at the previous edge.
   always_comb begin
      sel_ok    = 32'(sel) < STACKS;
      cur_sp    = sel_ok ? sp[sel] : '0;
      cur_full  = sel_ok && (cur_sp == CNT_W'(DEPTH));
      cur_empty = (cur_sp == '0);
      top_idx   = ADDR_W'(cur_sp - CNT_W'(1));
      wr_idx    = ADDR_W'(cur_sp);

      do_op    = req && !flush && sel_ok;
      is_push  = (op == OP_PUSH);
      push_ok  = do_op && is_push && !cur_full;
      push_rej = do_op && is_push && cur_full;
      rd_ok    = do_op && !is_push && !cur_empty;
      rd_rej   = do_op && !is_push && cur_empty;
      pop_ok   = rd_ok && (op == OP_POP);
      wr_en    = push_ok || (rd_ok && (op == OP_REPLACE));
      wr_addr  = push_ok ? wr_idx : top_idx;
   end

   assign count = cur_sp;
   assign full  = cur_full;
   assign empty = cur_empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < STACKS; s++) sp[s] <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         for (int s = 0; s < STACKS; s++) begin
            if (sel_ok && (sel == SEL_W'(s))) begin
               if (flush)        sp[s] <= '0;
               else if (push_ok) sp[s] <= sp[s] + CNT_W'(1);
               else if (pop_ok)  sp[s] <= sp[s] - CNT_W'(1);
            end
         end
         dout_valid <= rd_ok;
         overflow   <= push_rej;
         underflow  <= rd_rej;
         // Peek, pop and replace all return the pre-op top entry.
         if (rd_ok) dout <= mem[sel][top_idx];
      end
   end

   // Storage is deliberately left unreset; the pointer guards keep stale
   // entries from ever being returned.
   always_ff @(posedge clock) begin
      if (wr_en) mem[sel][wr_addr] <= din;
   end

   logic unused_peek_code;
   assign unused_peek_code = (OP_PEEK == 2'b00);

endmodule

// File: tb/tb_stack_bank.sv
// Directed and short randomised test of stack_bank against a per-stack
// array model, plus literal expectations taken from the test plan.
module tb_stack_bank;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 16;
   localparam int STACKS = 4;
   localparam int SEL_W  = 2;
   localparam int CNT_W  = 5;

   localparam logic [1:0] PEEK = 2'b00;
   localparam logic [1:0] PUSH = 2'b01;
   localparam logic [1:0] POP  = 2'b10;
   localparam logic [1:0] REPL = 2'b11;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             req   = 1'b0;
   logic [1:0]       op    = 2'b00;
   logic [SEL_W-1:0] sel   = '0;
   logic [WIDTH-1:0] din   = '0;
   logic             flush = 1'b0;
   logic [WIDTH-1:0] dout;
   logic             dout_valid, overflow, underflow, full, empty;
   logic [CNT_W-1:0] count;

   int errors = 0;
   int checks = 0;

   stack_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STACKS(STACKS)) dut (
      .clock(clock), .reset(reset), .req(req), .op(op), .sel(sel),
      .din(din), .flush(flush), .dout(dout), .dout_valid(dout_valid),
      .overflow(overflow), .underflow(underflow), .count(count),
      .full(full), .empty(empty)
   );

   // clock / reset
   always #5 clock = ~clock;

   // model: each stack is a plain array plus an occupancy count
   logic [WIDTH-1:0] m_data [STACKS][DEPTH];
   int               m_cnt  [STACKS];
   logic [WIDTH-1:0] e_dout = '0;
   logic             e_v = 1'b0, e_o = 1'b0, e_u = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STACKS; i++) m_cnt[i] = 0;
         e_dout = '0; e_v = 1'b0; e_o = 1'b0; e_u = 1'b0;
      end else begin
         e_v = 1'b0; e_o = 1'b0; e_u = 1'b0;
         if (int'(sel) < STACKS) begin
            if (flush) m_cnt[sel] = 0;
            else if (req) begin
               if (op == PUSH) begin
                  if (m_cnt[sel] == DEPTH) e_o = 1'b1;
                  else begin
                     m_data[sel][m_cnt[sel]] = din;
                     m_cnt[sel] = m_cnt[sel] + 1;
                  end
               end else if (m_cnt[sel] == 0) begin
                  e_u = 1'b1;
               end else begin
                  e_v    = 1'b1;
                  e_dout = m_data[sel][m_cnt[sel]-1];
                  if (op == REPL) m_data[sel][m_cnt[sel]-1] = din;
                  if (op == POP)  m_cnt[sel] = m_cnt[sel] - 1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // compare process: every negedge, all outputs against the model
   always @(negedge clock) begin
      int exp_cnt;
      exp_cnt = (int'(sel) < STACKS) ? m_cnt[sel] : 0;
      chk("dout",       dout,             e_dout);
      chk("dout_valid", 32'(dout_valid),  32'(e_v));
      chk("overflow",   32'(overflow),    32'(e_o));
      chk("underflow",  32'(underflow),   32'(e_u));
      chk("count",      32'(count),       32'(exp_cnt));
      chk("full",       32'(full),        32'(exp_cnt == DEPTH));
      chk("empty",      32'(empty),       32'(exp_cnt == 0));
   end

   // driver: one op per cycle, outputs observable on return
   task automatic step(input logic r, input logic [1:0] o, input int s,
                       input logic [WIDTH-1:0] d, input logic f);
      @(negedge clock);
      #1;
      req = r; op = o; sel = SEL_W'(s); din = d; flush = f;
      @(posedge clock);
      #1;
      req = 1'b0; flush = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      chk("rst_dout", dout, 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);

      // LIFO order on stack 1
      step(1, PUSH, 1, 32'hA, 0);
      step(1, PUSH, 1, 32'hB, 0);
      step(1, PUSH, 1, 32'hC, 0);
      chk("s1_count3", 32'(count), 32'd3);
      step(1, POP, 1, 0, 0);
      chk("pop_c", dout, 32'hC);
      chk("pop_c_v", 32'(dout_valid), 32'h1);
      step(1, POP, 1, 0, 0);
      chk("pop_b", dout, 32'hB);
      step(1, POP, 1, 0, 0);
      chk("pop_a", dout, 32'hA);
      chk("s1_empty", 32'(empty), 32'h1);
      chk("s1_count0", 32'(count), 32'd0);

      // fill stack 0 and overflow it
      for (int i = 0; i < DEPTH; i++) step(1, PUSH, 0, 32'h100 + 32'(i), 0);
      chk("s0_full", 32'(full), 32'h1);
      step(1, PUSH, 0, 32'hDEAD, 0);
      chk("ovf_pulse", 32'(overflow), 32'h1);
      chk("ovf_count", 32'(count), 32'd16);
      step(1, POP, 0, 0, 0);
      chk("ovf_pop", dout, 32'h10F);
      chk("ovf_cleared", 32'(overflow), 32'h0);

      // underflow on empty stack 2
      step(1, POP, 2, 0, 0);
      chk("unf_pop", 32'(underflow), 32'h1);
      chk("unf_hold", dout, 32'h10F);
      chk("unf_nv", 32'(dout_valid), 32'h0);
      step(1, PEEK, 2, 0, 0);
      chk("unf_peek", 32'(underflow), 32'h1);
      step(1, REPL, 2, 32'h77, 0);
      chk("unf_repl", 32'(underflow), 32'h1);

      // replace then peek on stack 3
      step(1, PUSH, 3, 32'h11, 0);
      step(1, REPL, 3, 32'h22, 0);
      chk("repl_old", dout, 32'h11);
      chk("repl_cnt", 32'(count), 32'd1);
      step(1, PEEK, 3, 0, 0);
      chk("peek_new", dout, 32'h22);
      chk("peek_cnt", 32'(count), 32'd1);

      // flush beats a simultaneous pop; other stacks untouched
      for (int i = 0; i < 3; i++) step(1, PUSH, 1, 32'h200 + 32'(i), 0);
      step(1, POP, 0, 0, 1);
      chk("flush_cnt", 32'(count), 32'd0);
      chk("flush_nv", 32'(dout_valid), 32'h0);
      chk("flush_nu", 32'(underflow), 32'h0);
      step(1, POP, 1, 0, 0);
      chk("s1_intact", dout, 32'h202);

      // back-to-back push then pop returns the fresh word
      step(1, PUSH, 1, 32'h55, 0);
      step(1, POP, 1, 0, 0);
      chk("b2b", dout, 32'h55);

      // reset mid-sequence with a pending dout_valid
      for (int i = 0; i < 4; i++) step(1, PUSH, 1, 32'h300 + 32'(i), 0);
      step(1, POP, 1, 0, 0);
      chk("pre_rst_cnt", 32'(count), 32'd5);
      chk("pre_rst_v", 32'(dout_valid), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_dout", dout, 32'h0);
      chk("mid_rst_v", 32'(dout_valid), 32'h0);
      chk("mid_rst_cnt", 32'(count), 32'd0);
      @(negedge clock);
      #1 reset = 1'b0;
      for (int s = 0; s < STACKS; s++) begin
         sel = SEL_W'(s);
         #1 chk("post_rst_empty", 32'(empty), 32'h1);
      end
      step(1, POP, 1, 0, 0);
      chk("post_rst_unf", 32'(underflow), 32'h1);

      // randomised mix, checked by the model every cycle
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, STACKS - 1), $urandom,
              $urandom_range(0, 24) == 0);
      end

      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
